// File: rtl/dso_cmd_regs.sv
// Framed UART command parser and DSO control-register file (sys_clk domain).
// Optional inter-byte timeout enabled by defining DSO_CMD_TIMEOUT_EN.
module dso_cmd_regs #(
  parameter logic [25:0] TIMEOUT_CYC  = 26'd5_000_000,
  parameter logic [9:0]  DECI_DEFAULT = 10'd1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        cfg_update,
  output logic [7:0]  trig_level,
  output logic [9:0]  deci_rate,
  output logic        wave_run,
  output logic        trig_edge,
  output logic [4:0]  v_scale,
  output logic        fft_en,
  output logic        fir_en,
  output logic [11:0] trig_line,
  input  logic [19:0] ad_freq,
  input  logic [7:0]  ad_vpp,
  input  logic [7:0]  ad_max,
  input  logic [7:0]  ad_min
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DHI, S_DLO, S_CHK, S_EXEC, S_RESP} state_t;

  state_t      state;
  logic [7:0]  cmd_q, dhi_q, dlo_q;
  logic [7:0]  resp_hi, resp_lo, resp_chk;
  logic [2:0]  resp_idx, resp_last;
  logic        nak_q;
  logic [19:0] freq_snap;
  logic [15:0] rd_word;
  logic [7:0]  next_byte;
  logic [3:0]  addr;
  logic        sum_ok, addr_ok, gap_hit;
  logic        unused_bits;

  function automatic logic [9:0] deci_clamp(input logic [9:0] d);
    return (d == 10'd0) ? 10'd1 : d;
  endfunction

  assign addr    = cmd_q[3:0];
  assign sum_ok  = (8'(cmd_q + dhi_q + dlo_q) == rx_data);
  assign addr_ok = (addr <= 4'h4) || (!cmd_q[7] && addr >= 4'h8 && addr <= 4'hB);

`ifdef DSO_CMD_TIMEOUT_EN
  logic [25:0] gap_cnt;
  logic        in_frame;

  assign in_frame = (state == S_CMD) || (state == S_DHI) || (state == S_DLO) || (state == S_CHK);
  assign gap_hit  = in_frame && !rx_valid && (gap_cnt >= TIMEOUT_CYC);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !in_frame || rx_valid || gap_hit) gap_cnt <= '0;
    else                                             gap_cnt <= gap_cnt + 26'd1;
  end

  assign unused_bits = ^freq_snap[19:16];
`else
  assign gap_hit     = 1'b0;
  assign unused_bits = ^{freq_snap[19:16], TIMEOUT_CYC};
`endif

  always_comb begin
    rd_word = '0;
    case (addr)
      4'h0: rd_word = {8'd0, trig_level};
      4'h1: rd_word = {6'd0, deci_rate};
      4'h2: rd_word = {12'd0, fir_en, fft_en, trig_edge, wave_run};
      4'h3: rd_word = {11'd0, v_scale};
      4'h4: rd_word = {4'd0, trig_line};
      4'h8: rd_word = {12'd0, ad_freq[19:16]};
      4'h9: rd_word = freq_snap[15:0];
      4'hA: rd_word = {8'd0, ad_vpp};
      4'hB: rd_word = {ad_max, ad_min};
      default: rd_word = '0;
    endcase
  end

  always_comb begin
    next_byte = cmd_q;
    case (resp_idx)
      3'd1:    next_byte = resp_hi;
      3'd2:    next_byte = resp_lo;
      3'd3:    next_byte = resp_chk;
      default: next_byte = cmd_q;
    endcase
  end

  // Frame capture and read-response data: no reset needed
  always_ff @(posedge sys_clk) begin
    if (rx_valid && state == S_CMD) cmd_q <= rx_data;
    if (rx_valid && state == S_DHI) dhi_q <= rx_data;
    if (rx_valid && state == S_DLO) dlo_q <= rx_data;
    if (state == S_EXEC) begin
      resp_hi  <= rd_word[15:8];
      resp_lo  <= rd_word[7:0];
      resp_chk <= 8'(cmd_q + rd_word[15:8] + rd_word[7:0]);
    end
  end

  // Control FSM, register file and TX handshake
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      tx_valid   <= 1'b0;
      tx_data    <= 8'd0;
      busy       <= 1'b0;
      cfg_update <= 1'b0;
      nak_q      <= 1'b0;
      resp_idx   <= '0;
      resp_last  <= '0;
      freq_snap  <= '0;
      trig_level <= 8'd127;
      deci_rate  <= DECI_DEFAULT;
      wave_run   <= 1'b1;
      trig_edge  <= 1'b1;
      v_scale    <= 5'b1_0010;
      fft_en     <= 1'b0;
      fir_en     <= 1'b0;
      trig_line  <= '0;
    end else begin
      case (state)
        S_IDLE: if (rx_valid && rx_data == 8'h55) state <= S_CMD;
        S_CMD:  if (rx_valid) state <= S_DHI; else if (gap_hit) state <= S_IDLE;
        S_DHI:  if (rx_valid) state <= S_DLO; else if (gap_hit) state <= S_IDLE;
        S_DLO:  if (rx_valid) state <= S_CHK; else if (gap_hit) state <= S_IDLE;
        S_CHK: begin
          // Accept/reject is decided here so cfg_update is a register high during EXEC
          if (rx_valid) begin
            nak_q      <= !(sum_ok && addr_ok);
            cfg_update <= sum_ok && addr_ok && cmd_q[7];
            busy       <= 1'b1;
            state      <= S_EXEC;
          end else if (gap_hit) begin
            state <= S_IDLE;
          end
        end
        S_EXEC: begin
          cfg_update <= 1'b0;
          tx_valid   <= 1'b1;
          resp_idx   <= '0;
          state      <= S_RESP;
          if (nak_q) begin
            tx_data   <= 8'hEE;
            resp_last <= 3'd1;
          end else if (cmd_q[7]) begin
            tx_data   <= 8'hAA;
            resp_last <= 3'd1;
            case (addr)
              4'h0: trig_level <= dlo_q;
              4'h1: deci_rate  <= deci_clamp({dhi_q[1:0], dlo_q});
              4'h2: {fir_en, fft_en, trig_edge, wave_run} <= dlo_q[3:0];
              4'h3: v_scale    <= dlo_q[4:0];
              4'h4: trig_line  <= {dhi_q[3:0], dlo_q};
              default: ;
            endcase
          end else begin
            tx_data   <= 8'hAA;
            resp_last <= 3'd4;
            if (addr == 4'h8) freq_snap <= ad_freq;
          end
        end
        S_RESP: begin
          if (tx_ready) begin
            if (resp_idx == resp_last) begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tx_data  <= next_byte;
              resp_idx <= resp_idx + 3'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dso_cmd_regs.sv
// Directed self-checking bench for dso_cmd_regs; covers DSO_CMD_TIMEOUT_EN when defined.
module tb_dso_cmd_regs;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy, cfg_update;
  logic [7:0]  trig_level;
  logic [9:0]  deci_rate;
  logic        wave_run, trig_edge, fft_en, fir_en;
  logic [4:0]  v_scale;
  logic [11:0] trig_line;
  logic [19:0] ad_freq = 20'd0;
  logic [7:0]  ad_vpp = 8'd0, ad_max = 8'd0, ad_min = 8'd0;

  int n_total = 0;
  int n_pass  = 0;
  int cfg_cnt = 0;
  int cfg_base;
  logic [7:0] txq[$];

  dso_cmd_regs #(.TIMEOUT_CYC(26'd100), .DECI_DEFAULT(10'd1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .cfg_update(cfg_update), .trig_level(trig_level), .deci_rate(deci_rate),
    .wave_run(wave_run), .trig_edge(trig_edge), .v_scale(v_scale), .fft_en(fft_en),
    .fir_en(fir_en), .trig_line(trig_line), .ad_freq(ad_freq), .ad_vpp(ad_vpp),
    .ad_max(ad_max), .ad_min(ad_min)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (cfg_update) cfg_cnt++;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    txq.delete();
    for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8]);
  endtask

  // exp holds the response bytes left-aligned, first byte in bits 39:32
  task automatic expect_resp(input string tag, input int n, input logic [39:0] exp);
    int k = 0;
    while (txq.size() < n && k < 100) begin
      tick();
      k++;
    end
    repeat (4) tick();
    check({tag, "_len"}, txq.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), (i < txq.size()) ? {24'd0, txq[i]} : 32'hDEAD, {24'd0, exp[39-8*i -: 8]});
    check({tag, "_idle"}, {busy, tx_valid}, 2'b00);
  endtask

  initial begin
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();

    // Reset state
    check("rst_trig_level", trig_level, 8'd127);
    check("rst_deci", deci_rate, 10'd1);
    check("rst_run_edge", {wave_run, trig_edge}, 2'b11);
    check("rst_vscale", v_scale, 5'h12);
    check("rst_fft_fir", {fft_en, fir_en}, 2'b00);
    check("rst_trig_line", trig_line, 12'd0);
    check("rst_tx_busy_cfg", {tx_valid, busy, cfg_update}, 3'b000);

    // Read 0x0 with latency check
    send_frame(40'h55_00_00_00_00);
    check("lat_exec", {busy, tx_valid}, 2'b10);
    tick();
    check("lat_first", {tx_valid, tx_data}, {1'b1, 8'hAA});
    expect_resp("rd0", 5, 40'hAA_00_00_7F_7F);

    // deci_rate writes, including the zero clamp
    cfg_base = cfg_cnt;
    send_frame(40'h55_81_00_00_81);
    check("wr_cfg_exec", cfg_update, 1'b1);
    tick();
    check("wr_cfg_drop", cfg_update, 1'b0);
    expect_resp("wr1_zero", 2, 40'hAA_81_000000);
    check("deci_zero", deci_rate, 10'd1);
    check("cfg_once", cfg_cnt - cfg_base, 1);
    send_frame(40'h55_81_03_E8_6C);
    expect_resp("wr1_1000", 2, 40'hAA_81_000000);
    check("deci_1000", deci_rate, 10'd1000);
    send_frame(40'h55_81_00_00_81);
    expect_resp("wr1_zero2", 2, 40'hAA_81_000000);
    check("deci_clamp", deci_rate, 10'd1);

    // NAK cases change nothing
    cfg_base = cfg_cnt;
    send_frame(40'h55_80_00_40_00);
    expect_resp("badchk", 2, 40'hEE_80_000000);
    check("badchk_tl", trig_level, 8'd127);
    send_frame(40'h55_8A_00_01_8B);
    expect_resp("wr_ro", 2, 40'hEE_8A_000000);
    send_frame(40'h55_05_00_00_05);
    expect_resp("rd_hole", 2, 40'hEE_05_000000);
    check("nak_no_cfg", cfg_cnt - cfg_base, 0);

    // Flags, trig_line masking, read-back, ignored CMD[6:4]
    send_frame(40'h55_82_00_0A_8C);
    expect_resp("wr2", 2, 40'hAA_82_000000);
    check("flags", {fir_en, fft_en, trig_edge, wave_run}, 4'b1010);
    send_frame(40'h55_02_00_00_02);
    expect_resp("rd2", 5, 40'hAA_02_00_0A_0C);
    send_frame(40'h55_84_FA_BC_3A);
    expect_resp("wr4", 2, 40'hAA_84_000000);
    check("trig_line", trig_line, 12'hABC);
    send_frame(40'h55_04_00_00_04);
    expect_resp("rd4", 5, 40'hAA_04_0A_BC_CA);
    send_frame(40'h55_70_00_00_70);
    expect_resp("rd0_hibits", 5, 40'hAA_70_00_7F_EF);

    // Measurement reads and tear-free frequency snapshot
    ad_freq = 20'hABCDE; ad_vpp = 8'h5A; ad_max = 8'hC8; ad_min = 8'h10;
    send_frame(40'h55_08_00_00_08);
    expect_resp("rd8", 5, 40'hAA_08_00_0A_12);
    ad_freq = 20'h12345;
    send_frame(40'h55_09_00_00_09);
    expect_resp("rd9", 5, 40'hAA_09_BC_DE_A3);
    send_frame(40'h55_0A_00_00_0A);
    expect_resp("rdA", 5, 40'hAA_0A_00_5A_64);
    send_frame(40'h55_0B_00_00_0B);
    expect_resp("rdB", 5, 40'hAA_0B_C8_10_E3);

    // 0x55 inside a frame is data
    send_frame(40'h55_80_00_55_D5);
    expect_resp("wr0_55", 2, 40'hAA_80_000000);
    check("tl_55", trig_level, 8'h55);

    // Backpressure with rx traffic while busy
    cfg_base = cfg_cnt;
    tx_ready = 1'b0;
    send_frame(40'h55_00_00_00_00);
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold_%0d", i), {tx_valid, tx_data}, {1'b1, 8'hAA});
      if (i < 5) send_byte((i == 0) ? 8'h55 : 8'h80);
      else tick();
    end
    tx_ready = 1'b1;
    expect_resp("hold_rd", 5, 40'hAA_00_00_55_55);
    check("busy_rx_ignored", trig_level, 8'h55);
    check("busy_no_cfg", cfg_cnt - cfg_base, 0);

    // Reset in the middle of a response
    tx_ready = 1'b0;
    send_frame(40'h55_00_00_00_00);
    tick();
    check("mid_tx", tx_valid, 1'b1);
    sys_rst = 1'b1;
    tick();
    check("mid_rst_tx", {tx_valid, busy}, 2'b00);
    check("mid_rst_regs", {trig_level, deci_rate, fir_en, trig_line}, {8'd127, 10'd1, 1'b0, 12'd0});
    sys_rst = 1'b0;
    tx_ready = 1'b1;
    repeat (3) tick();
    check("mid_rst_nobytes", txq.size(), 0);

`ifdef DSO_CMD_TIMEOUT_EN
    txq.delete();
    send_byte(8'h55); send_byte(8'h80);
    repeat (101) tick();
    send_frame(40'h55_00_00_00_00);
    expect_resp("to_expire", 5, 40'hAA_00_00_7F_7F);
    check("to_expire_tl", trig_level, 8'd127);
    txq.delete();
    send_byte(8'h55); send_byte(8'h80);
    repeat (99) tick();
    send_byte(8'h00); send_byte(8'h60); send_byte(8'hE0);
    expect_resp("to_hold", 2, 40'hAA_80_000000);
    check("to_hold_tl", trig_level, 8'h60);
`else
    txq.delete();
    send_byte(8'h55); send_byte(8'h00);
    repeat (150) tick();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    expect_resp("no_timeout", 5, 40'hAA_00_00_7F_7F);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
